// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: turns IR/DR scan, TAP-reset and idle-run commands into
// registered TMS/TDI step sequences, tracking the target TAP state in a shadow.
module jtag_scan_sequencer (
    input  logic        TCK,
    input  logic        TRST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [4:0]  CMD_LEN,
    input  logic [31:0] CMD_DATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO,
    output logic        BUSY
);

    typedef enum logic [3:0] {
        TAP_EXIT2_DR = 4'h0, TAP_EXIT1_DR = 4'h1, TAP_SHIFT_DR = 4'h2, TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4, TAP_UPD_DR   = 4'h5, TAP_CAP_DR   = 4'h6, TAP_SEL_DR   = 4'h7,
        TAP_EXIT2_IR = 4'h8, TAP_EXIT1_IR = 4'h9, TAP_SHIFT_IR = 4'hA, TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC, TAP_UPD_IR   = 4'hD, TAP_CAP_IR   = 4'hE, TAP_TLR      = 4'hF
    } tap_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_PRE = 3'd1, ST_RESET_SEQ = 3'd2, ST_ENTER = 3'd3,
        ST_SHIFT = 3'd4, ST_EXIT = 3'd5, ST_RUN = 3'd6
    } state_t;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b11;

    function automatic tap_t tap_step(input tap_t s, input logic t);
        case (s)
            TAP_TLR:      return t ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      return t ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   return t ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   return t ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: return t ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: return t ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: return t ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: return t ? TAP_UPD_DR : TAP_SHIFT_DR;
            TAP_UPD_DR:   return t ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   return t ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   return t ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: return t ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: return t ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: return t ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: return t ? TAP_UPD_IR : TAP_SHIFT_IR;
            TAP_UPD_IR:   return t ? TAP_SEL_DR : TAP_RTI;
            default:      return TAP_TLR;
        endcase
    endfunction

    state_t      state_reg, state_next;
    tap_t        tap_reg, tap_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [1:0]  op_reg, op_next;
    logic [4:0]  len_reg, len_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] cap_reg, cap_next;
    logic [31:0] rsp_data_reg;
    logic        tms_reg, tms_next, tdi_reg, tdi_next;
    logic        rsp_valid_reg, done, live_reg;

    // live_reg keeps READY low until the first edge after reset release.
    assign CMD_READY = live_reg && (state_reg == ST_IDLE);
    assign BUSY      = ~CMD_READY;
    assign TMS       = tms_reg;
    assign TDI       = tdi_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_DATA  = rsp_data_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        len_next   = len_reg;
        data_next  = data_reg;
        cap_next   = cap_reg;
        done       = 1'b0;
        tap_next   = tap_step(tap_reg, tms_reg);

        case (state_reg)
            ST_IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    op_next   = CMD_OP;
                    len_next  = CMD_LEN;
                    data_next = CMD_DATA;
                    cap_next  = '0;
                    cnt_next  = '0;
                    if (CMD_OP == OP_RESET)
                        state_next = ST_RESET_SEQ;
                    else if (tap_reg == TAP_TLR)
                        state_next = ST_PRE;
                    else if (CMD_OP == OP_RUN)
                        state_next = ST_RUN;
                    else
                        state_next = ST_ENTER;
                end
            end
            ST_PRE: begin
                cnt_next   = '0;
                state_next = (op_reg == OP_RUN) ? ST_RUN : ST_ENTER;
            end
            ST_RESET_SEQ: begin
                if (cnt_reg == 6'd4) begin
                    state_next = ST_IDLE;
                    done       = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            ST_ENTER: begin
                if (cnt_reg == ((op_reg == OP_IR) ? 6'd3 : 6'd2)) begin
                    state_next = ST_SHIFT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            ST_SHIFT: begin
                cap_next[cnt_reg[4:0]] = TDO;
                if (cnt_reg == {1'b0, len_reg}) begin
                    state_next = ST_EXIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            ST_EXIT: begin
                if (cnt_reg == 6'd1) begin
                    state_next = ST_IDLE;
                    done       = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            ST_RUN: begin
                if (cnt_reg == {1'b0, len_reg}) begin
                    state_next = ST_IDLE;
                    done       = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                tap_next   = TAP_TLR;
            end
        endcase

        // Outputs are decoded from the step about to be driven so TMS/TDI stay registered.
        tms_next = 1'b0;
        tdi_next = 1'b0;
        case (state_next)
            ST_IDLE:      tms_next = (tap_next == TAP_TLR);
            ST_RESET_SEQ: tms_next = 1'b1;
            ST_ENTER:     tms_next = (cnt_next == 6'd0) || ((op_next == OP_IR) && (cnt_next == 6'd1));
            ST_SHIFT: begin
                tms_next = (cnt_next == {1'b0, len_next});
                tdi_next = data_next[cnt_next[4:0]];
            end
            ST_EXIT:      tms_next = (cnt_next == 6'd0);
            default:      tms_next = 1'b0;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_reg     <= ST_IDLE;
            tap_reg       <= TAP_TLR;
            cnt_reg       <= '0;
            op_reg        <= '0;
            len_reg       <= '0;
            data_reg      <= '0;
            cap_reg       <= '0;
            rsp_data_reg  <= '0;
            tms_reg       <= 1'b1;
            tdi_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            live_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tap_reg       <= tap_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            len_reg       <= len_next;
            data_reg      <= data_next;
            cap_reg       <= cap_next;
            tms_reg       <= tms_next;
            tdi_reg       <= tdi_next;
            rsp_valid_reg <= done;
            live_reg      <= 1'b1;
            if (done)
                rsp_data_reg <= cap_next;
        end
    end

endmodule

// File: doc/jtag_scan_sequencer.md
JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are TCK and TRST.
REQ-002 TCK  input  1  sole clock; all state updates on posedge.
REQ-003 TRST  input  1  asynchronous active-low reset.
REQ-004 CMD_VALID  input  1  command request.
REQ-005 CMD_READY  output  1  block can accept a command.
REQ-006 CMD_OP  input  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 idle-run.
REQ-007 CMD_LEN  input  5  count field; N = CMD_LEN+1 (1..32) shift bits or idle cycles.
REQ-008 CMD_DATA  input  32  TDI payload, bit 0 shifted first.
REQ-009 RSP_VALID  output  1  one-cycle completion pulse.
REQ-010 RSP_DATA  output  32  captured TDO bits, bit 0 first captured.
REQ-011 TMS  output  1  registered TMS to target TAP.
REQ-012 TDI  output  1  registered TDI to target TAP.
REQ-013 TDO  input  1  serial data from target TAP.
REQ-014 BUSY  output  1  high while a command sequence is in progress.

Function
REQ-015 The block SHALL keep a shadow of the 16-state TAP state, updated every posedge from the TMS value it drives.
REQ-016 A command SHALL be accepted at a posedge where CMD_VALID and CMD_READY are both high; CMD_OP/LEN/DATA are latched there.
REQ-017 CMD_READY SHALL be high only in internal state IDLE; BUSY = ~CMD_READY.
REQ-018 Internal FSM states: IDLE, PRE, RESET_SEQ, ENTER, SHIFT, EXIT, RUN; unused encodings go to IDLE with shadow = Test-Logic-Reset.
REQ-019 With accept at posedge t0 and a sequence of S steps, step k SHALL be driven on TMS/TDI after posedge t0+k-1 (k=1..S).
REQ-020 If the shadow is Test-Logic-Reset at accept, ops 01/10/11 SHALL prepend one PRE step TMS=0 (to Run-Test/Idle).
REQ-021 Op 00: RESET_SEQ, five steps TMS=1, shadow ends Test-Logic-Reset, from any shadow state.
REQ-022 Op 01 from Run-Test/Idle: ENTER TMS 1,1,0,0; SHIFT N steps; EXIT TMS 1,0; ends Run-Test/Idle.
REQ-023 Op 10 from Run-Test/Idle: ENTER TMS 1,0,0; SHIFT N steps; EXIT TMS 1,0; ends Run-Test/Idle.
REQ-024 SHIFT step i (0..N-1): TDI = CMD_DATA[i]; TMS = 0 for i<N-1, 1 for i=N-1 (Exit1 entered directly, no Pause).
REQ-025 TDO SHALL be sampled at the posedge ending shift step i into RSP_DATA[i]; bits N..31 SHALL be 0.
REQ-026 Op 11: RUN, N steps TMS=0, ends Run-Test/Idle.
REQ-027 TDI SHALL be 0 on every non-SHIFT step and in IDLE.
REQ-028 In IDLE, TMS SHALL be 1 if the shadow is Test-Logic-Reset, else 0, so the TAP holds its state.
REQ-029 After posedge t0+S: RSP_VALID=1 for exactly one cycle, CMD_READY=1, back-to-back accept allowed at that same posedge.
REQ-030 RSP_DATA SHALL hold its value until the next completion; for ops 00/11 it SHALL be 0x00000000.
REQ-031 Step counter: 6 bits; no wrap; N=32 SHALL shift exactly 32 bits.
REQ-032 CMD_VALID while busy SHALL be ignored, not queued.

Reset
REQ-033 While TRST=0: TMS=1, TDI=0, CMD_READY=0, BUSY=1, RSP_VALID=0, RSP_DATA=0, shadow = Test-Logic-Reset, FSM = IDLE.
REQ-034 First posedge after TRST release: CMD_READY=1, BUSY=0, TMS=1.
REQ-035 TRST assertion mid-command SHALL abort it immediately: no RSP_VALID, latched command discarded.

Verification
REQ-036 Reset then op 11, LEN=2 -> S=4: TMS 0,0,0,0; RSP_VALID at t0+4; RSP_DATA=0.
REQ-037 From Run-Test/Idle, op 01, LEN=3, DATA=0xA -> S=10: TMS 1,1,0,0,0,0,0,1,1,0; TDI on shift steps 0,1,0,1; shadow ends Run-Test/Idle.
REQ-038 From Test-Logic-Reset, op 10, LEN=7, TDO=1 only on shift steps 0 and 7 -> S=14, RSP_DATA=0x00000081.
REQ-039 Op 10, LEN=31, DATA=0xDEADBEEF, TDO looped to TDI one step late -> 32 shift steps, RSP_DATA=0xBD5B7DDE (DATA<<1).
REQ-040 Op 00 from Shift-DR mid-stream (after TRST-free abort via op boundary) -> five TMS=1, shadow Test-Logic-Reset, IDLE TMS=1.
REQ-041 TRST pulsed low at step 5 of a DR scan -> no RSP_VALID, TMS=1, next accepted command begins with PRE step.
